// File: rtl/fir_stim_source.sv
// fir_stim_source: programmable sample-playback source with gap insertion and zero flush tail for the FIR input
module fir_stim_source #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int TAPS  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [3:0]    wr_data,
  input  logic [AW:0]   len,
  input  logic [3:0]    gap,
  input  logic          start,
  input  logic          abort,
  output logic [3:0]    In,
  output logic          in_valid,
  output logic          busy,
  output logic          done,
  output logic          wr_err
);
  typedef enum logic [2:0] {IDLE, PLAY, GAP, FLUSH, DONE} state_t;
  localparam int FW = $clog2(TAPS) + 1;
  state_t st, ns;
  logic [AW-1:0] idx, idx_n;
  logic [3:0] gcnt, gcnt_n, gap_q, gap_n, rd;
  logic [AW:0] len_q, len_n;
  logic [FW-1:0] fcnt, fcnt_n;
  logic [3:0] mem [DEPTH];
  logic last;
  // next-state, counters and the sample to present in the next cycle
  always_comb begin
    ns = st;
    idx_n = idx;
    gcnt_n = gcnt;
    fcnt_n = fcnt;
    len_n = len_q;
    gap_n = gap_q;
    last = {1'b0, idx} == len_q - (AW+1)'(1);
    case (st)
      IDLE: if (start) begin
        if (len == '0) ns = DONE;
        else begin
          ns = PLAY;
          idx_n = '0;
          len_n = len;
          gap_n = gap;
        end
      end
      PLAY: if (abort) ns = DONE;
        else if (last) begin
          ns = TAPS > 1 ? FLUSH : DONE;
          fcnt_n = FW'(TAPS - 1);
        end else if (gap_q != 4'd0) begin
          ns = GAP;
          gcnt_n = gap_q;
        end else idx_n = idx + AW'(1);
      GAP: if (abort) ns = DONE;
        else if (gcnt == 4'd1) begin
          ns = PLAY;
          idx_n = idx + AW'(1);
          gcnt_n = 4'd0;
        end else gcnt_n = gcnt - 4'd1;
      FLUSH: if (abort) ns = DONE;
        else if (fcnt == FW'(1)) ns = DONE;
        else fcnt_n = fcnt - FW'(1);
      DONE: ns = IDLE;
      default: ns = IDLE;
    endcase
    rd = (st == IDLE && wr_en && wr_addr == idx_n) ? wr_data : mem[idx_n];
  end
  // state, counters and registered outputs derived from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
      idx <= '0;
      gcnt <= '0;
      fcnt <= '0;
      len_q <= '0;
      gap_q <= '0;
      In <= '0;
      in_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      wr_err <= 1'b0;
    end else begin
      st <= ns;
      idx <= idx_n;
      gcnt <= gcnt_n;
      fcnt <= fcnt_n;
      len_q <= len_n;
      gap_q <= gap_n;
      In <= ns == PLAY ? rd : 4'd0;
      in_valid <= ns == PLAY || ns == FLUSH;
      busy <= ns != IDLE;
      done <= ns == DONE;
      wr_err <= wr_en && st != IDLE;
    end
  end
  // pattern buffer; writes only land while idle
  always_ff @(posedge clk) begin
    if (wr_en && st == IDLE) mem[wr_addr] <= wr_data;
  end
endmodule

// File: tb/tb_fir_stim_source.sv
// tb_fir_stim_source: directed playback vectors checked cycle by cycle
module tb_fir_stim_source;
  logic clk = 0, rst = 1, wr_en = 0, start = 0, abort = 0;
  logic [3:0] wr_addr = 0, wr_data = 0, gap = 0, In;
  logic [4:0] len = 0;
  logic in_valid, busy, done, wr_err;
  int checks = 0, failures = 0;
  localparam logic [7:0] GW = 8'h02, FW = 8'h06, DW = 8'h03, IW = 8'h00;

  fir_stim_source #(.DEPTH(16), .AW(4), .TAPS(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .len(len), .gap(gap), .start(start), .abort(abort),
    .In(In), .in_valid(in_valid), .busy(busy), .done(done), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] smp(input logic [3:0] v);
    return {1'b0, v, 3'b110};
  endfunction

  function automatic logic [7:0] obs();
    return {1'b0, In, in_valid, busy, done};
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 0;
    check("wr_err_idle", {7'b0, wr_err}, 8'h00);
  endtask

  task automatic go(input logic [4:0] l, input logic [3:0] g);
    start = 1; len = l; gap = g;
    tick();
    start = 0;
  endtask

  task automatic expect_seq(input string tag, input logic [7:0] seq[$]);
    foreach (seq[i]) begin
      if (i > 0) tick();
      check(tag, obs(), seq[i]);
    end
  endtask

  initial begin
    int n, guard;
    #12;
    check("reset_out", obs(), IW);
    check("reset_wr_err", {7'b0, wr_err}, 8'h00);
    rst = 0;
    tick();
    wr(0, 1);
    go(1, 0);
    expect_seq("len1", '{smp(1), FW, FW, FW, DW, IW});
    wr(0, 4); wr(1, 4'hC); wr(2, 7);
    go(3, 2);
    expect_seq("gap2", '{smp(4), GW, GW, smp(4'hC), GW, GW, smp(7), FW, FW, FW, DW, IW});
    for (int i = 0; i < 16; i++) wr(4'(i), 4'(i));
    go(16, 0);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) tick();
      check("len16", obs(), smp(4'(i)));
    end
    tick();
    expect_seq("len16_tail", '{FW, FW, FW, DW, IW});
    go(8, 0);
    expect_seq("abort_pre", '{smp(0), smp(1), smp(2)});
    abort = 1;
    tick();
    abort = 0;
    expect_seq("abort_post", '{DW, IW});
    go(8, 0);
    check("replay0", obs(), smp(0));
    abort = 1;
    tick();
    abort = 0;
    expect_seq("abort2", '{DW, IW});
    go(4, 1);
    wr_en = 1; wr_addr = 1; wr_data = 9;
    tick();
    wr_en = 0;
    check("wr_err_play", {7'b0, wr_err}, 8'h01);
    start = 1; len = 8;
    tick();
    start = 0;
    check("wr_err_clear", {7'b0, wr_err}, 8'h00);
    n = 3; guard = 0;
    while (busy && guard < 40) begin
      tick();
      guard++;
      if (busy) n++;
    end
    check("busy_bound", {7'b0, guard >= 40}, 8'h00);
    check("busy_cycles", 8'(n), 8'd11);
    tick();
    check("no_requeue", obs(), IW);
    go(2, 0);
    expect_seq("wr_reject", '{smp(0), smp(1), FW, FW, FW, DW, IW});
    go(0, 0);
    expect_seq("len0", '{DW, IW});
    wr_en = 1; wr_addr = 0; wr_data = 5;
    go(1, 0);
    wr_en = 0;
    expect_seq("wr_start_same", '{smp(5), FW, FW, FW, DW, IW});
    go(16, 0);
    tick(); tick();
    check("pre_rst", obs(), smp(2));
    #3 rst = 1;
    #1 check("rst_async", obs(), IW);
    #2 rst = 0;
    tick();
    check("rst_no_done1", obs(), IW);
    tick();
    check("rst_no_done2", obs(), IW);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fir_stim_source.md
# fir_stim_source

Programmable sample-playback source driving the 4-bit signed input of the FIR datapath. A small pattern buffer is loaded over a write port. On `start` it streams the stored samples one per sample slot, with an optional per-sample gap, then drives a zero-valued flush tail so the filter drains. It is the producer end of the FIR input stream and replaces hand-written stimulus sequences with on-chip playback.

## Interface
- `DEPTH`, 16: pattern buffer entries; a power of two, at most 256.
- `AW`, 4: buffer address width; must equal log2(DEPTH).
- `TAPS`, 4: FIR tap count; the flush tail is TAPS-1 zero samples.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `wr_en` in 1: buffer write strobe.
- `wr_addr` in AW: buffer write address.
- `wr_data` in 4: signed sample to store.
- `len` in AW+1: number of samples to play, 0..DEPTH; sampled on accepted `start`.
- `gap` in 4: idle cycles inserted after each played sample; sampled on accepted `start`.
- `start` in 1: begin playback; level-sampled.
- `abort` in 1: terminate playback immediately.
- `In` out 4: signed sample to the FIR `In` input; registered.
- `in_valid` out 1: `In` carries a stream sample (played or flush).
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when playback completes or is aborted.
- `wr_err` out 1: one-cycle pulse when a write is rejected.

## Operation
- States: IDLE, PLAY, GAP, FLUSH, DONE.
- IDLE:
  - `In`=0, `in_valid`=0.
  - If `start`=1 and `len`≥1: latch `len` and `gap`, set idx=0, go to PLAY.
  - If `start`=1 and `len`=0: go to DONE. Nothing is played and there is no flush.
- PLAY:
  - `In`=mem[idx], `in_valid`=1, for exactly one cycle.
  - Then: if idx=len-1, go to FLUSH.
  - Otherwise, if the latched gap>0, go to GAP.
  - Otherwise stay in PLAY with idx+1.
- GAP:
  - `In`=0, `in_valid`=0 for exactly `gap` cycles, then return to PLAY with idx+1.
- FLUSH:
  - `In`=0, `in_valid`=1 for exactly TAPS-1 cycles, then go to DONE.
  - With TAPS=1, skip FLUSH and go straight to DONE.
- DONE:
  - `done`=1, `In`=0, `in_valid`=0 for one cycle, then go to IDLE.
  - `busy` is still 1 in DONE.
- `start` while busy is ignored. It is not queued.
- Writes:
  - `wr_en` in IDLE writes mem[wr_addr]←wr_data.
  - `wr_en` in any other state does not write and pulses `wr_err` on the next cycle.
  - Buffer contents survive playback and `abort`. Contents are undefined after `rst`.
- `abort`:
  - In PLAY, GAP or FLUSH: the next state is DONE. `In` is 0 from that edge on and no further samples or flush are emitted.
  - In IDLE or DONE: ignored.
  - `abort` has priority over every other transition in the same cycle.
- Width rules:
  - idx is AW bits. The comparison uses `len`-1 (AW+1 bits), so `len`=DEPTH plays mem[0..DEPTH-1] with no wrap.
  - The gap counter is 4 bits; `gap`=15 yields 15 idle cycles.
  - `In` is emitted as stored, 4-bit two's complement; no sign conversion is performed.

## Timing
- Reset values:
  - State IDLE.
  - `In`=0, `in_valid`=0, `busy`=0, `done`=0, `wr_err`=0.
  - idx=0, gap counter=0.
- All outputs are registered and change only on the rising `clk` edge, except on reset assertion.
- Start latency: with `start` high at edge k, the first sample is on `In` in the cycle after edge k, with `busy`=1 in the same cycle.
- Total busy cycles for `len`=L≥1 with latched gap G: L + (L-1)·G + (TAPS-1) + 1.
  - Example: L=3, G=0, TAPS=4 gives 7.
  - There are no gap cycles after the last sample.
- `len`=0: `busy` and `done` both high for exactly one cycle after the start edge.
- A write accepted at edge k is visible to a playback started at edge k+1. A write and `start` at the same edge in IDLE both take effect, and the write precedes the read.
- `rst` mid-playback: all outputs return to reset values asynchronously. No `done` pulse is issued.
- A new `start` is accepted on the cycle after DONE, i.e. back-to-back runs are separated by one IDLE cycle.

## Test plan
- Load mem[0]=1, `len`=1, `gap`=0, `start`:
  - `In` sequence 1,0,0,0 with `in_valid`=1 for 4 cycles.
  - Then `done` for 1 cycle; total `busy` = 5 cycles.
- Load {4,−4(0xC),7}, `len`=3, `gap`=2:
  - `In` sequence 4,0,0,−4,0,0,7, then 3 flush zeros.
  - `in_valid` pattern 1,0,0,1,0,0,1,1,1,1, then `done`.
- `len`=16 over {0..15}, `gap`=0:
  - `In` steps 0 through 15 (8..15 read as −8..−1), no wrap, then 3 flush cycles and `done`.
- Start a `len`=8 run, assert `abort` during the 3rd sample:
  - `In`=0 and `done`=1 on the next cycle, then IDLE.
  - A following `start` replays from mem[0].
- `wr_en` asserted during PLAY:
  - `wr_err` pulses, and the buffer is unchanged on replay.
  - A `start` asserted mid-run has no effect.
- `len`=0 `start`:
  - `done` and `busy` high for one cycle; `in_valid` never asserts.
  - Assert `rst` mid-run in a separate run: outputs clear immediately and no `done` pulse follows.
